vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/pixel_clk_en.sv | 44 ++++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Shared VGA timing constants, total helpers and coordinate types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int COORD_W      = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Coordinate shared with the pixel generator.
    typedef logic [COORD_W-1:0] coord_t;
    // One bit wider so window bounds equal to 1024 stay representable.
    typedef logic [COORD_W:0]   bound_t;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_clk_en.sv
// ============================================================================
// Module : pixel_clk_en
// Brief  : Divides the system clock into a per-pixel tick and first-clk flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o,
    output logic first_o
);

    // A one-bit counter is kept even for CLK_DIV==1; it then never leaves 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == c_div_last) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o  = (div_q == c_div_last);
    assign first_o = (div_q == '0);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Brief  : VGA raster counters, sync decode and pixel/line/frame strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [9:0]   h_cnt_o,
    output logic [9:0]   v_cnt_o,
    output logic         valid_o,
    output logic         hsync_n_o,
    output logic         vsync_n_o,
    output logic         pix_stb_o,
    output logic         line_start_o,
    output logic         frame_start_o
);

    localparam int c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if ((c_h_total > 1024) || (c_v_total > 1024) || (CLK_DIV < 1)) begin : g_bad_params
            $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    localparam coord_t c_h_last   = coord_t'(c_h_total - 1);
    localparam coord_t c_v_last   = coord_t'(c_v_total - 1);
    localparam bound_t c_h_act    = bound_t'(H_ACTIVE);
    localparam bound_t c_v_act    = bound_t'(V_ACTIVE);
    localparam bound_t c_hs_begin = bound_t'(H_ACTIVE + H_FP);
    localparam bound_t c_hs_end   = bound_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam bound_t c_vs_begin = bound_t'(V_ACTIVE + V_FP);
    localparam bound_t c_vs_end   = bound_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   w_pix_tick;
    logic   w_pix_first;
    coord_t hc_q, hc_d;
    coord_t vc_q, vc_d;
    bound_t w_h_ext, w_v_ext;

    logic   valid_d, hsync_n_d, vsync_n_d, pix_stb_d, line_start_d, frame_start_d;
    coord_t h_cnt_q, v_cnt_q;
    logic   valid_q, hsync_n_q, vsync_n_q, pix_stb_q, line_start_q, frame_start_q;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_en (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_o  (w_pix_tick),
        .first_o (w_pix_first)
    );

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (w_pix_tick) begin
            if (hc_q == c_h_last) begin
                hc_d = '0;
                vc_d = (vc_q == c_v_last) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Decode the pre-edge state so every output lags it by exactly one clk.
    assign w_h_ext = {1'b0, hc_q};
    assign w_v_ext = {1'b0, vc_q};

    always_comb begin
        valid_d       = (w_h_ext < c_h_act) && (w_v_ext < c_v_act);
        hsync_n_d     = !((w_h_ext >= c_hs_begin) && (w_h_ext < c_hs_end));
        vsync_n_d     = !((w_v_ext >= c_vs_begin) && (w_v_ext < c_vs_end));
        pix_stb_d     = w_pix_first;
        line_start_d  = w_pix_first && (hc_q == '0);
        frame_start_d = line_start_d && (vc_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            valid_q       <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= hc_q;
            v_cnt_q       <= vc_q;
            valid_q       <= valid_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            pix_stb_q     <= pix_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign valid_o       = valid_q;
    assign hsync_n_o     = hsync_n_q;
    assign vsync_n_o     = vsync_n_q;
    assign pix_stb_o     = pix_stb_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire
